// File: rtl/uart_ook_pkg.sv
// uart_ook_pkg: shared constants, encoder state type and chip pattern helper
package uart_ook_pkg;
    localparam int MODE_RAW = 0;
    localparam int MODE_PWM = 1;
    localparam int MODE_MAN = 2;
    localparam int SYNC_HI_CHIPS = 1;
    localparam int SYNC_LO_CHIPS = 31;
    localparam int CHIPS_PER_BIT = 4;

    typedef logic [1:0] enc_state_t;
    localparam enc_state_t ST_IDLE = 2'd0;
    localparam enc_state_t ST_LOAD = 2'd1;
    localparam enc_state_t ST_SYNC = 2'd2;
    localparam enc_state_t ST_DATA = 2'd3;

    // Level of chip k (0..63) of one repetition: 32 sync chips, then 8 bits MSB-first
    function automatic logic chip_level(input int mode, input logic [7:0] b, input logic [5:0] k);
        logic bit_v;
        logic [1:0] ph;
        bit_v = b[3'd7 - k[4:2]];
        ph = k[1:0];
        if (!k[5])
            return k[4:0] < 5'(SYNC_HI_CHIPS);
        return mode == MODE_MAN ? (bit_v ? !ph[1] : ph[1]) : (bit_v ? ph != 2'd3 : ph == 2'd0);
    endfunction
endpackage

// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 receiver on an already synchronised line, start bit confirmed at mid-bit
module uart_rx_8n1 #(
    parameter int BAUD_DIV = 1250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;
    localparam logic [1:0] R_STOP = 2'd3;

    logic [1:0] state;
    logic [CW-1:0] cnt;
    logic [2:0] bit_idx;
    logic rx_prev;
    logic half_end, baud_end;

    assign half_end = cnt == CW'(BAUD_DIV / 2 - 1);
    assign baud_end = cnt == CW'(BAUD_DIV - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= R_IDLE;
            cnt <= '0;
            bit_idx <= '0;
            rx_prev <= 1'b1;
            data <= '0;
            valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_prev <= rx;
            valid <= 1'b0;
            frame_err <= 1'b0;
            cnt <= (state == R_IDLE || (state == R_START ? half_end : baud_end)) ? '0 : cnt + CW'(1);
            if (state == R_IDLE) begin
                state <= (rx_prev && !rx) ? R_START : R_IDLE;
            end else if (state == R_START) begin
                if (half_end)
                    state <= rx ? R_IDLE : R_DATA;
            end else if (baud_end) begin
                if (state == R_DATA) begin
                    data <= {rx, data[7:1]};
                    bit_idx <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7)
                        state <= R_STOP;
                end else begin
                    valid <= rx;
                    frame_err <= !rx;
                    state <= R_IDLE;
                end
            end
        end
    end
endmodule

// File: rtl/uart_ook_encoder.sv
// uart_ook_encoder: UART bytes buffered in a FIFO and keyed out as repeated OOK chip frames
module uart_ook_encoder
    import uart_ook_pkg::*;
#(
    parameter int BAUD_DIV = 1250,
    parameter int CHIP_CLKS = 3600,
    parameter int FIFO_DEPTH = 16,
    parameter int REPEAT = 4,
    parameter int MODE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic uart_rx,
    output logic rf_tx,
    output logic busy,
    output logic overflow,
    output logic frame_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(CHIP_CLKS);

    logic sync_1, sync_n, rx_sync;
    logic [7:0] rx_data;
    logic rx_valid;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0] count;
    logic full, push, pop;
    enc_state_t state;
    logic [TW-1:0] tmr;
    logic [5:0] chip;
    logic [3:0] rep;
    logic [7:0] cur;
    logic rf_q, chip_end, last_chip, done;

    // Second stage stores the inverted line so raw mode keys straight from a flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b1;
            sync_n <= 1'b0;
        end else begin
            sync_1 <= uart_rx;
            sync_n <= ~sync_1;
        end
    end

    assign rx_sync = ~sync_n;

    uart_rx_8n1 #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk(clk),
        .rst(rst),
        .rx(rx_sync),
        .data(rx_data),
        .valid(rx_valid),
        .frame_err(frame_err)
    );

    assign full = count == (AW+1)'(FIFO_DEPTH);
    assign pop = state == ST_LOAD;
    assign push = rx_valid && (!full || pop);

    always_ff @(posedge clk)
        if (push)
            mem[wr_ptr] <= rx_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= rx_valid && full && !pop;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    assign chip_end = tmr == TW'(CHIP_CLKS - 1);
    assign last_chip = chip == 6'(SYNC_HI_CHIPS + SYNC_LO_CHIPS + 8 * CHIPS_PER_BIT - 1);
    assign done = last_chip && rep == 4'(REPEAT - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            tmr <= '0;
            chip <= '0;
            rep <= '0;
            cur <= '0;
            rf_q <= 1'b0;
        end else if (state == ST_IDLE) begin
            rf_q <= 1'b0;
            if (MODE != MODE_RAW && count != '0)
                state <= ST_LOAD;
        end else if (state == ST_LOAD) begin
            cur <= mem[rd_ptr];
            tmr <= '0;
            chip <= '0;
            rep <= '0;
            rf_q <= chip_level(MODE, mem[rd_ptr], 6'd0);
            state <= ST_SYNC;
        end else begin
            tmr <= chip_end ? '0 : tmr + TW'(1);
            if (chip_end) begin
                chip <= chip + 6'd1;
                rf_q <= done ? 1'b0 : chip_level(MODE, cur, chip + 6'd1);
                if (last_chip) begin
                    rep <= rep + 4'd1;
                    state <= done ? ST_IDLE : ST_SYNC;
                end else if (chip == 6'(SYNC_HI_CHIPS + SYNC_LO_CHIPS - 1)) begin
                    state <= ST_DATA;
                end
            end
        end
    end

    assign rf_tx = MODE == MODE_RAW ? sync_n : rf_q;
    assign busy = MODE != MODE_RAW && (count != '0 || state != ST_IDLE);
endmodule
